uart_rx_fifo: RTL and testbench
===============================

Name: uart_rx_fifo

Overview:
- Byte buffer directly downstream of the UART receiver.
- Captures each received byte on the receiver's rdy/data pair and returns the rdy_clr handshake, so every byte is taken exactly once.
- Stores bytes in a DEPTH-entry circular FIFO and presents them to the consumer as a first-word-fall-through valid/ready stream.
- Reports fill level and a sticky overflow flag.

Parameters:
- DEPTH, 16: FIFO entries; power of 2, 4 to 256.
- AW, $clog2(DEPTH): pointer address width; derived, never overridden.
- THRESH, 12: level threshold for irq, range 1..DEPTH; used only when UART_RX_FIFO_IRQ_EN is defined.

Ports:
- clk_50m  input  1  system clock; all state changes on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- rx_rdy  input  1  receiver byte-ready flag.
- rx_data  input  8  receiver byte; valid while rx_rdy=1.
- rx_rdy_clr  output  1  clear request back to the receiver.
- m_data  output  8  head-of-FIFO byte.
- m_valid  output  1  FIFO non-empty.
- m_ready  input  1  consumer accepts m_data this cycle.
- count  output  AW+1  bytes currently stored, 0..DEPTH.
- overflow  output  1  sticky; a byte was dropped because the FIFO was full.
- ovf_clr  input  1  clears overflow.
- irq  output  1  present only with UART_RX_FIFO_IRQ_EN.

Behaviour:
- Reset (rst_n=0, async): state=IDLE; wr_ptr=rd_ptr=0; count=0; m_valid=0; m_data=8'h00; rx_rdy_clr=0; overflow=0; irq=0. Memory contents are not reset.
- Reset mid-handshake discards all stored bytes. After release, a still-high rx_rdy is captured once as a new byte.
- Pointers are AW+1 bits. empty = (wr_ptr==rd_ptr). full = (MSBs differ, low AW bits equal).
- count = wr_ptr - rd_ptr, registered; +1 on push, -1 on pop, unchanged on push+pop.
- Capture FSM, two states:
  - IDLE: rx_rdy=0 -> stay, rx_rdy_clr=0. rx_rdy=1 at edge N -> push attempt at edge N, go to WAIT, rx_rdy_clr=1 from edge N.
  - WAIT: rx_rdy_clr=1. Stay while sampled rx_rdy=1. Sampled rx_rdy=0 -> IDLE, rx_rdy_clr=0.
  - Nominal: rx_rdy_clr is high 2 cycles (edges N to N+2). Minimum spacing between captured bytes is 3 cycles.
  - A stuck-high rx_rdy holds WAIT indefinitely and never produces a duplicate push.
- Push: mem[wr_ptr[AW-1:0]] <= rx_data; wr_ptr++.
  - Accepted when !full, or when full with a pop in the same cycle.
  - Otherwise the byte is dropped, overflow <= 1, and the handshake still completes normally.
- Pop: when m_valid && m_ready at an edge, rd_ptr++. m_ready while empty is ignored.
- m_valid = !empty. m_data = mem[rd_ptr[AW-1:0]] when non-empty, else 8'h00.
- First-word-fall-through: a byte pushed at edge N is visible on m_data/m_valid after edge N; latency is 1 cycle from rx_rdy sampled high.
- Pointers wrap naturally modulo 2*DEPTH; there are no special cases at wrap.
- overflow: a set condition and ovf_clr in the same cycle -> overflow stays 1 (set wins).

Optional Feature:
- UART_RX_FIFO_IRQ_EN defined:
  - adds output irq, registered: irq <= (next count >= THRESH) | (next overflow).
  - deasserts one cycle after the level falls below THRESH and overflow is clear.
- Not defined: no irq port, no THRESH logic; all other behaviour identical.

Test Plan:
- Single byte: rx_rdy=1 with rx_data=8'hA5 for 2 cycles, then 0; m_ready=0 -> rx_rdy_clr high 2 cycles, m_valid=1, m_data=8'hA5, count=1; then m_ready=1 for 1 cycle -> m_valid=0, count=0, m_data=8'h00.
- Fill/overflow: DEPTH=16, push bytes 0x00..0x10 (17 bytes), no pops -> count=16, overflow=1; drain 16 bytes -> m_data order 0x00..0x0F, byte 0x10 absent; ovf_clr=1 -> overflow=0.
- Full plus simultaneous push/pop: FIFO full with head 0x00, byte 0x55 arrives while m_ready=1 -> count stays 16, overflow=0, 0x55 is the last byte drained.
- Wrap-around: 40 bytes streamed with m_ready=1 continuously -> all 40 received in order, count never exceeds 1, overflow=0.
- Stuck/reset: rx_rdy held high 20 cycles -> exactly one push, rx_rdy_clr high throughout. rst_n pulsed low mid-WAIT with count=3 -> count=0, m_valid=0, rx_rdy_clr=0 immediately.
- IRQ (macro defined, THRESH=12): push 11 bytes -> irq=0; 12th byte -> irq=1 next cycle; pop one -> irq=0 next cycle.

Source files
------------

// File: rtl/uart_rx_fifo_if.sv
// Consumer-side stream of the UART receive FIFO (first-word-fall-through).
// master drives m_data/m_valid and samples m_ready; slave is the consumer.
interface uart_rx_fifo_if;
   logic [7:0] m_data;
   logic       m_valid;
   logic       m_ready;

   modport master (
      output m_data,
      output m_valid,
      input  m_ready
   );

   modport slave (
      input  m_data,
      input  m_valid,
      output m_ready
   );
endinterface

// File: rtl/uart_rx_fifo.sv
// Byte FIFO behind a UART receiver: captures rx_rdy/rx_data once per byte via
// the rx_rdy_clr handshake and streams bytes out on a valid/ready interface.
// Ports: clk_50m, rst_n (async, active low); rx_rdy, rx_data, rx_rdy_clr
// (receiver side); m (stream, master modport); count (fill level);
// overflow (sticky drop flag), ovf_clr (its clear); irq (only with the
// UART_RX_FIFO_IRQ_EN macro, asserted at level >= THRESH or on overflow).
module uart_rx_fifo #(
   parameter int DEPTH = 16
`ifdef UART_RX_FIFO_IRQ_EN
   ,
   parameter int THRESH = 12
`endif
) (
   input  logic                   clk_50m,
   input  logic                   rst_n,
   input  logic                   rx_rdy,
   input  logic [7:0]             rx_data,
   output logic                   rx_rdy_clr,
   uart_rx_fifo_if.master         m,
   output logic [$clog2(DEPTH):0] count,
   output logic                   overflow,
   input  logic                   ovf_clr
`ifdef UART_RX_FIFO_IRQ_EN
   ,
   output logic                   irq
`endif
);
   localparam int AW = $clog2(DEPTH);

   typedef enum logic {IDLE, WAIT} state_t;

   state_t      state;
   state_t      state_n;
   logic        push_req;
   logic        push;
   logic        pop;
   logic        drop;
   logic        empty;
   logic        full;
   logic        ovf_n;
   logic [AW:0] cnt_n;
   logic [AW:0] wr_ptr;
   logic [AW:0] rd_ptr;
   logic [7:0]  mem [DEPTH];

   always_ff @(posedge clk_50m or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_n;
   end

   // A byte is taken only on the IDLE->WAIT transition, so a stuck rx_rdy
   // parks in WAIT and can never produce a second push.
   always_comb begin
      state_n  = state;
      push_req = 1'b0;
      unique case (state)
         IDLE: begin
            if (rx_rdy) begin
               push_req = 1'b1;
               state_n  = WAIT;
            end
         end
         WAIT: begin
            if (!rx_rdy) state_n = IDLE;
         end
      endcase
   end

   assign rx_rdy_clr = (state == WAIT);

   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW])
               && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign pop   = !empty && m.m_ready;
   // When full, a same-cycle pop frees the slot the push will use.
   assign push  = push_req && (!full || pop);
   assign drop  = push_req && !push;
   assign ovf_n = drop | (overflow & ~ovf_clr);

   always_comb begin
      cnt_n = count;
      if (push && !pop)      cnt_n = count + (AW+1)'(1);
      else if (!push && pop) cnt_n = count - (AW+1)'(1);
   end

   always_ff @(posedge clk_50m or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
         if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
         count    <= cnt_n;
         overflow <= ovf_n;
      end
   end

   always_ff @(posedge clk_50m) begin
      if (push) mem[wr_ptr[AW-1:0]] <= rx_data;
   end

   assign m.m_valid = !empty;
   assign m.m_data  = empty ? 8'h00 : mem[rd_ptr[AW-1:0]];

`ifdef UART_RX_FIFO_IRQ_EN
   always_ff @(posedge clk_50m or negedge rst_n) begin
      if (!rst_n) irq <= 1'b0;
      else        irq <= (cnt_n >= (AW+1)'(THRESH)) | ovf_n;
   end
`endif
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed self-checking bench for uart_rx_fifo (DEPTH=16).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_uart_rx_fifo;
   logic       clk_50m = 1'b0;
   logic       rst_n   = 1'b0;
   logic       rx_rdy  = 1'b0;
   logic [7:0] rx_data = 8'h00;
   logic       rx_rdy_clr;
   logic [4:0] count;
   logic       overflow;
   logic       ovf_clr = 1'b0;
`ifdef UART_RX_FIFO_IRQ_EN
   logic       irq;
`endif

   int checks = 0;
   int passed = 0;

   uart_rx_fifo_if ifc ();

   uart_rx_fifo #(.DEPTH(16)) dut (
      .clk_50m    (clk_50m),
      .rst_n      (rst_n),
      .rx_rdy     (rx_rdy),
      .rx_data    (rx_data),
      .rx_rdy_clr (rx_rdy_clr),
      .m          (ifc.master),
      .count      (count),
      .overflow   (overflow),
      .ovf_clr    (ovf_clr)
`ifdef UART_RX_FIFO_IRQ_EN
      ,
      .irq        (irq)
`endif
   );

   always #5 clk_50m = ~clk_50m;

   task automatic send_byte(input logic [7:0] b);
      rx_rdy  = 1'b1;
      rx_data = b;
      @(negedge clk_50m);
      @(negedge clk_50m);
      rx_rdy = 1'b0;
      @(negedge clk_50m);
   endtask

   task automatic test_reset;
      ifc.m_ready = 1'b0;
      @(negedge clk_50m);
      checks++;
      if (count !== 5'd0 || ifc.m_valid !== 1'b0 || ifc.m_data !== 8'h00
          || rx_rdy_clr !== 1'b0 || overflow !== 1'b0)
         $display("FAIL reset: cnt=%0d v=%b d=%h clr=%b ovf=%b want 0/0/00/0/0",
                  count, ifc.m_valid, ifc.m_data, rx_rdy_clr, overflow);
      else passed++;
      rst_n = 1'b1;
      @(negedge clk_50m);
   endtask

   task automatic test_single;
      rx_rdy  = 1'b1;
      rx_data = 8'hA5;
      @(negedge clk_50m);
      checks++;
      if (rx_rdy_clr !== 1'b1 || ifc.m_valid !== 1'b1
          || ifc.m_data !== 8'hA5 || count !== 5'd1)
         $display("FAIL single_push: clr=%b v=%b d=%h cnt=%0d want 1/1/a5/1",
                  rx_rdy_clr, ifc.m_valid, ifc.m_data, count);
      else passed++;
      @(negedge clk_50m);
      checks++;
      if (rx_rdy_clr !== 1'b1)
         $display("FAIL single_clr2: clr=%b want 1", rx_rdy_clr);
      else passed++;
      rx_rdy = 1'b0;
      @(negedge clk_50m);
      checks++;
      if (rx_rdy_clr !== 1'b0 || count !== 5'd1 || ifc.m_data !== 8'hA5)
         $display("FAIL single_idle: clr=%b cnt=%0d d=%h want 0/1/a5",
                  rx_rdy_clr, count, ifc.m_data);
      else passed++;
      ifc.m_ready = 1'b1;
      @(negedge clk_50m);
      ifc.m_ready = 1'b0;
      checks++;
      if (ifc.m_valid !== 1'b0 || count !== 5'd0 || ifc.m_data !== 8'h00)
         $display("FAIL single_pop: v=%b cnt=%0d d=%h want 0/0/00",
                  ifc.m_valid, count, ifc.m_data);
      else passed++;
   endtask

   task automatic test_fill_overflow;
      for (int i = 0; i < 16; i++) send_byte(8'(i));
      checks++;
      if (count !== 5'd16 || overflow !== 1'b0)
         $display("FAIL fill_16: cnt=%0d ovf=%b want 16/0", count, overflow);
      else passed++;
      // 17th byte dropped while ovf_clr is high on the same edge: set wins
      ovf_clr = 1'b1;
      rx_rdy  = 1'b1;
      rx_data = 8'h10;
      @(negedge clk_50m);
      ovf_clr = 1'b0;
      @(negedge clk_50m);
      rx_rdy = 1'b0;
      @(negedge clk_50m);
      checks++;
      if (count !== 5'd16 || overflow !== 1'b1)
         $display("FAIL overflow_set: cnt=%0d ovf=%b want 16/1", count, overflow);
      else passed++;
      ifc.m_ready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         checks++;
         if (ifc.m_data !== 8'(i) || ifc.m_valid !== 1'b1)
            $display("FAIL drain_%0d: d=%h v=%b want %h/1",
                     i, ifc.m_data, ifc.m_valid, 8'(i));
         else passed++;
         @(negedge clk_50m);
      end
      ifc.m_ready = 1'b0;
      checks++;
      if (ifc.m_valid !== 1'b0 || count !== 5'd0)
         $display("FAIL drain_empty: v=%b cnt=%0d want 0/0", ifc.m_valid, count);
      else passed++;
      ovf_clr = 1'b1;
      @(negedge clk_50m);
      ovf_clr = 1'b0;
      checks++;
      if (overflow !== 1'b0)
         $display("FAIL ovf_clr: ovf=%b want 0", overflow);
      else passed++;
   endtask

   task automatic test_full_push_pop;
      for (int i = 0; i < 16; i++) send_byte(8'(i));
      rx_rdy      = 1'b1;
      rx_data     = 8'h55;
      ifc.m_ready = 1'b1;
      @(negedge clk_50m);
      ifc.m_ready = 1'b0;
      checks++;
      if (count !== 5'd16 || overflow !== 1'b0 || ifc.m_data !== 8'h01)
         $display("FAIL full_pushpop: cnt=%0d ovf=%b d=%h want 16/0/01",
                  count, overflow, ifc.m_data);
      else passed++;
      @(negedge clk_50m);
      rx_rdy = 1'b0;
      @(negedge clk_50m);
      ifc.m_ready = 1'b1;
      for (int i = 1; i < 17; i++) begin
         logic [7:0] exp;
         exp = (i == 16) ? 8'h55 : 8'(i);
         checks++;
         if (ifc.m_data !== exp)
            $display("FAIL fpp_drain_%0d: d=%h want %h", i, ifc.m_data, exp);
         else passed++;
         @(negedge clk_50m);
      end
      ifc.m_ready = 1'b0;
      checks++;
      if (count !== 5'd0 || ifc.m_valid !== 1'b0)
         $display("FAIL fpp_empty: cnt=%0d v=%b want 0/0", count, ifc.m_valid);
      else passed++;
   endtask

   task automatic test_wrap;
      int maxc = 0;
      ifc.m_ready = 1'b1;
      for (int i = 0; i < 40; i++) begin
         logic [7:0] b;
         b       = 8'(i * 7 + 3);
         rx_rdy  = 1'b1;
         rx_data = b;
         @(negedge clk_50m);
         if (int'(count) > maxc) maxc = int'(count);
         checks++;
         if (ifc.m_data !== b || ifc.m_valid !== 1'b1)
            $display("FAIL wrap_%0d: d=%h v=%b want %h/1",
                     i, ifc.m_data, ifc.m_valid, b);
         else passed++;
         @(negedge clk_50m);
         if (int'(count) > maxc) maxc = int'(count);
         rx_rdy = 1'b0;
         @(negedge clk_50m);
      end
      ifc.m_ready = 1'b0;
      checks++;
      if (maxc != 1 || overflow !== 1'b0 || count !== 5'd0)
         $display("FAIL wrap_level: max=%0d ovf=%b cnt=%0d want 1/0/0",
                  maxc, overflow, count);
      else passed++;
   endtask

   task automatic test_stuck;
      int clr_lo = 0;
      rx_rdy  = 1'b1;
      rx_data = 8'h3C;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk_50m);
         if (rx_rdy_clr !== 1'b1) clr_lo++;
      end
      checks++;
      if (clr_lo != 0 || count !== 5'd1)
         $display("FAIL stuck: clr_low_cycles=%0d cnt=%0d want 0/1", clr_lo, count);
      else passed++;
      rx_rdy = 1'b0;
      @(negedge clk_50m);
      checks++;
      if (rx_rdy_clr !== 1'b0 || count !== 5'd1 || ifc.m_data !== 8'h3C)
         $display("FAIL stuck_release: clr=%b cnt=%0d d=%h want 0/1/3c",
                  rx_rdy_clr, count, ifc.m_data);
      else passed++;
      ifc.m_ready = 1'b1;
      @(negedge clk_50m);
      ifc.m_ready = 1'b0;
   endtask

   task automatic test_reset_mid;
      send_byte(8'h11);
      send_byte(8'h22);
      rx_rdy  = 1'b1;
      rx_data = 8'h33;
      @(negedge clk_50m);
      checks++;
      if (count !== 5'd3 || rx_rdy_clr !== 1'b1)
         $display("FAIL pre_reset: cnt=%0d clr=%b want 3/1", count, rx_rdy_clr);
      else passed++;
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (count !== 5'd0 || ifc.m_valid !== 1'b0 || rx_rdy_clr !== 1'b0)
         $display("FAIL async_reset: cnt=%0d v=%b clr=%b want 0/0/0",
                  count, ifc.m_valid, rx_rdy_clr);
      else passed++;
      @(negedge clk_50m);
      rst_n   = 1'b1;
      rx_data = 8'h44;
      @(negedge clk_50m);
      @(negedge clk_50m);
      rx_rdy = 1'b0;
      @(negedge clk_50m);
      @(negedge clk_50m);
      checks++;
      if (count !== 5'd1 || ifc.m_data !== 8'h44 || overflow !== 1'b0)
         $display("FAIL post_reset_capture: cnt=%0d d=%h ovf=%b want 1/44/0",
                  count, ifc.m_data, overflow);
      else passed++;
      ifc.m_ready = 1'b1;
      @(negedge clk_50m);
      ifc.m_ready = 1'b0;
   endtask

`ifdef UART_RX_FIFO_IRQ_EN
   task automatic test_irq;
      for (int i = 0; i < 11; i++) send_byte(8'(i + 8'h80));
      checks++;
      if (irq !== 1'b0)
         $display("FAIL irq_11: irq=%b want 0", irq);
      else passed++;
      send_byte(8'h8B);
      checks++;
      if (irq !== 1'b1)
         $display("FAIL irq_12: irq=%b want 1", irq);
      else passed++;
      ifc.m_ready = 1'b1;
      @(negedge clk_50m);
      ifc.m_ready = 1'b0;
      checks++;
      if (irq !== 1'b0 || count !== 5'd11)
         $display("FAIL irq_pop: irq=%b cnt=%0d want 0/11", irq, count);
      else passed++;
      ifc.m_ready = 1'b1;
      repeat (11) @(negedge clk_50m);
      ifc.m_ready = 1'b0;
   endtask
`endif

   initial begin
      ifc.m_ready = 1'b0;
      test_reset();
      test_single();
      test_fill_overflow();
      test_full_push_pop();
      test_wrap();
      test_stuck();
      test_reset_mid();
`ifdef UART_RX_FIFO_IRQ_EN
      test_irq();
`endif
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
